// File: rtl/value_change_recorder.sv
// value_change_recorder: timestamps changes of `in` into a record FIFO.
// Define VCR_INIT_RECORD_EN to also record the initial value in the priming cycle.
module value_change_recorder #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in,
  input  logic                       en,
  output logic                       rec_valid,
  input  logic                       rec_ready,
  output logic [TS_W-1:0]            rec_time,
  output logic                       rec_value,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [TS_W-1:0] ts_q, ts_d;
  logic            prev_q, prime_q, overflow_q, overflow_d;
  logic [AW:0]     wr_q, wr_d, rd_q, rd_d;
  logic [TS_W:0]   mem_q [DEPTH];
  logic            change, push, pop, full, accept;
`ifdef VCR_INIT_RECORD_EN
  assign change = prime_q || (in != prev_q);
`else
  assign change = !prime_q && (in != prev_q);
`endif
  assign push       = change && en;
  assign count      = wr_q - rd_q;
  assign rec_valid  = count != '0;
  assign full       = count == (AW+1)'(DEPTH);
  assign pop        = rec_valid && rec_ready;
  // a push into a full FIFO is only accepted when the head leaves in the same cycle
  assign accept     = push && (!full || pop);
  assign ts_d       = ts_q + 1'b1;
  assign wr_d       = accept ? wr_q + 1'b1 : wr_q;
  assign rd_d       = pop ? rd_q + 1'b1 : rd_q;
  assign overflow_d = overflow_q || (push && !accept);
  assign {rec_time, rec_value} = mem_q[rd_q[AW-1:0]];
  assign overflow   = overflow_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q       <= '0;
      prev_q     <= 1'b0;
      prime_q    <= 1'b1;
      overflow_q <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
    end else begin
      ts_q       <= ts_d;
      prev_q     <= in;
      prime_q    <= 1'b0;
      overflow_q <= overflow_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
    end
  end
  always_ff @(posedge clk)
    if (accept) mem_q[wr_q[AW-1:0]] <= {ts_q, in};
endmodule
